// File: rtl/ddp_pkg.sv
// Shared constants for the JOIN/branch packet network cells.
// Holds the handshake FSM state encoding and the grant encoding.
package ddp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/mg_arb_rr_pick2.sv
// Combinational two-way round-robin selector.
// A lone requester always wins; a tie goes to whichever side holds prio.
module rr_pick2
    import ddp_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic prio,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req_a | req_b;
        winner = GNT_A;
        if (req_a && req_b) begin
            winner = prio;
        end else if (req_b) begin
            winner = GNT_B;
        end
    end

endmodule

// File: rtl/mg_arb.sv
// Two-input merge arbiter: joins requesters a and b onto one four-phase
// Send/Ack channel with round-robin fairness and fully registered outputs.
module mg_arb
    import ddp_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          MR,
    input  logic          MG_Send_in_a,
    input  logic [DW-1:0] MG_Data_in_a,
    input  logic          MG_Send_in_b,
    input  logic [DW-1:0] MG_Data_in_b,
    input  logic          MG_Ack_in,
    output logic          MG_Ack_out_a,
    output logic          MG_Ack_out_b,
    output logic          MG_Send_out,
    output logic [DW-1:0] MG_Data_out,
    output logic          MG_Gnt,
    output logic          MG_Busy,
    output logic          MG_CP
);

    state_t        state, state_d;
    logic          prio, prio_d;
    logic          send_d, ack_a_d, ack_b_d, gnt_d, cp_d;
    logic [DW-1:0] data_d;
    logic          pick_valid, pick_winner;
    logic          owner_send;

    rr_pick2 u_pick (
        .req_a  (MG_Send_in_a),
        .req_b  (MG_Send_in_b),
        .prio   (prio),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    assign owner_send = (MG_Gnt == GNT_B) ? MG_Send_in_b : MG_Send_in_a;

    always_comb begin
        state_d = state;
        prio_d  = prio;
        send_d  = MG_Send_out;
        ack_a_d = MG_Ack_out_a;
        ack_b_d = MG_Ack_out_b;
        data_d  = MG_Data_out;
        gnt_d   = MG_Gnt;
        cp_d    = 1'b0;
        case (state)
            IDLE: begin
                // A high Ack_in here is a downstream protocol error: hold off granting.
                if (!MG_Ack_in && pick_valid) begin
                    data_d  = (pick_winner == GNT_B) ? MG_Data_in_b : MG_Data_in_a;
                    gnt_d   = pick_winner;
                    send_d  = 1'b1;
                    cp_d    = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (MG_Ack_in) begin
                    send_d = 1'b0;
                    if (MG_Gnt == GNT_B) ack_b_d = 1'b1;
                    else                 ack_a_d = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!owner_send && !MG_Ack_in) begin
                    ack_a_d = 1'b0;
                    ack_b_d = 1'b0;
                    prio_d  = ~MG_Gnt;
                    state_d = IDLE;
                end
            end
            default: begin
                send_d  = 1'b0;
                ack_a_d = 1'b0;
                ack_b_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            state        <= IDLE;
            prio         <= GNT_A;
            MG_Send_out  <= 1'b0;
            MG_Ack_out_a <= 1'b0;
            MG_Ack_out_b <= 1'b0;
            MG_Data_out  <= '0;
            MG_Gnt       <= GNT_A;
            MG_Busy      <= 1'b0;
            MG_CP        <= 1'b0;
        end else begin
            state        <= state_d;
            prio         <= prio_d;
            MG_Send_out  <= send_d;
            MG_Ack_out_a <= ack_a_d;
            MG_Ack_out_b <= ack_b_d;
            MG_Data_out  <= data_d;
            MG_Gnt       <= gnt_d;
            MG_Busy      <= (state_d != IDLE);
            MG_CP        <= cp_d;
        end
    end

endmodule

// File: tb/tb_mg_arb.sv
// Bench for mg_arb: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_mg_arb;

    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          MR  = 1'b1;
    logic          sa = 1'b0, sb = 1'b0, ack_in = 1'b0;
    logic [DW-1:0] da = '0, db = '0;
    logic          ack_a, ack_b, send_out, gnt, busy, cp;
    logic [DW-1:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    mg_arb #(.DW(DW)) dut (
        .CLK          (CLK),
        .MR           (MR),
        .MG_Send_in_a (sa),
        .MG_Data_in_a (da),
        .MG_Send_in_b (sb),
        .MG_Data_in_b (db),
        .MG_Ack_in    (ack_in),
        .MG_Ack_out_a (ack_a),
        .MG_Ack_out_b (ack_b),
        .MG_Send_out  (send_out),
        .MG_Data_out  (data_out),
        .MG_Gnt       (gnt),
        .MG_Busy      (busy),
        .MG_CP        (cp)
    );

    always #5 CLK = ~CLK;

    // Transaction-level reference: one transfer in flight, owned by one side,
    // either waiting for downstream ack or waiting for the four-phase release.
    bit            m_in_xfer, m_acked, m_owner, m_turn, m_cp;
    logic [DW-1:0] m_data;

    always @(posedge CLK or posedge MR) begin
        if (MR) begin
            m_in_xfer = 0; m_acked = 0; m_owner = 0; m_turn = 0; m_cp = 0; m_data = '0;
        end else begin
            m_cp = 0;
            if (!m_in_xfer) begin
                if (!ack_in && (sa || sb)) begin
                    m_owner   = (sa && sb) ? m_turn : sb;
                    m_data    = m_owner ? db : da;
                    m_in_xfer = 1;
                    m_acked   = 0;
                    m_cp      = 1;
                end
            end else if (!m_acked) begin
                if (ack_in) m_acked = 1;
            end else if (!(m_owner ? sb : sa) && !ack_in) begin
                m_in_xfer = 0;
                m_turn    = !m_owner;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("model send_out", send_out, m_in_xfer && !m_acked);
            chk("model ack_a", ack_a, m_in_xfer && m_acked && !m_owner);
            chk("model ack_b", ack_b, m_in_xfer && m_acked && m_owner);
            chk("model busy", busy, m_in_xfer);
            chk("model cp", cp, m_cp);
            chk("model gnt", gnt, m_owner);
            chk("model data", data_out, m_data);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        tick();
        #1 MR = 1'b1;
        tick();
        #1 MR = 1'b0;
    endtask

    task automatic wait_send(input string nm);
        int k = 0;
        while (!send_out && k < 20) begin
            tick();
            k++;
        end
        chk({nm, " send_out timeout"}, send_out, 1'b1);
    endtask

    initial begin
        tick(2);
        #1 MR = 1'b0;
        tick();
        cmp_en = 1'b1;
        chk("reset send_out", send_out, 0);
        chk("reset busy", busy, 0);
        chk("reset data", data_out, 0);
        chk("reset gnt", gnt, 0);
        chk("reset cp", cp, 0);

        // single a
        sa = 1; da = 16'hA5A5;
        tick();
        chk("single send_out", send_out, 1);
        chk("single data", data_out, 16'hA5A5);
        chk("single gnt", gnt, 0);
        chk("single cp", cp, 1);
        tick();
        chk("single cp pulse", cp, 0);
        ack_in = 1;
        tick();
        chk("single ack_a", ack_a, 1);
        chk("single send drop", send_out, 0);
        sa = 0; ack_in = 0;
        tick();
        chk("single ack_a release", ack_a, 0);
        chk("single busy", busy, 0);

        // simultaneous after reset: a, b, a, b
        do_reset();
        da = 16'h1111; db = 16'h2222; sa = 1; sb = 1;
        for (int i = 0; i < 4; i++) begin
            wait_send("rr");
            chk("rr gnt", gnt, i % 2);
            chk("rr data", data_out, (i % 2) ? 16'h2222 : 16'h1111);
            ack_in = 1;
            tick();
            chk("rr ack", (i % 2) ? ack_b : ack_a, 1);
            if (i % 2) sb = 0; else sa = 0;
            ack_in = 0;
            tick();
            if (i % 2) sb = 1; else sa = 1;
        end
        sa = 0; sb = 0;
        tick(3);

        // Ack_in stuck high in IDLE blocks grants
        do_reset();
        ack_in = 1; sb = 1; db = 16'h0B0B;
        tick(3);
        chk("ackhi send_out", send_out, 0);
        chk("ackhi busy", busy, 0);
        ack_in = 0;
        tick();
        chk("ackhi late send", send_out, 1);
        chk("ackhi late gnt", gnt, 1);
        ack_in = 1; tick(); sb = 0; ack_in = 0; tick(2);

        // ACK exit orderings, all on requester a
        for (int mode = 0; mode < 3; mode++) begin
            do_reset();
            sa = 1; da = 16'h0C0C + mode[15:0];
            tick();
            ack_in = 1;
            tick();
            chk("exit in ack", ack_a, 1);
            if (mode == 0) begin
                ack_in = 0; tick(3);
                chk("exit hold (ack first)", ack_a, 1);
                sa = 0; tick();
            end else if (mode == 1) begin
                sa = 0; tick(3);
                chk("exit hold (send first)", ack_a, 1);
                ack_in = 0; tick();
            end else begin
                sa = 0; ack_in = 0; tick();
            end
            chk("exit release", ack_a, 0);
            chk("exit idle", busy, 0);
        end

        // async reset mid REQ
        do_reset();
        sa = 1; sb = 1; da = 16'h1234; db = 16'h5678;
        tick(); sb = 0;
        tick();
        chk("mr pre send", send_out, 1);
        #2 MR = 1'b1;
        #1;
        chk("mr async send", send_out, 0);
        chk("mr async busy", busy, 0);
        chk("mr async data", data_out, 0);
        chk("mr async acks", {ack_a, ack_b}, 0);
        tick();
        sb = 1;
        #1 MR = 1'b0;
        tick();
        chk("mr regrant gnt", gnt, 0);
        chk("mr regrant send", send_out, 1);
        ack_in = 1; tick(); sa = 0; sb = 0; ack_in = 0; tick(3);

        // protocol violation: b drops in REQ
        do_reset();
        sb = 1; db = 16'hBEEF;
        tick();
        chk("viol gnt", gnt, 1);
        sb = 0;
        tick(2);
        chk("viol send held", send_out, 1);
        ack_in = 1;
        tick();
        chk("viol ack_b", ack_b, 1);
        ack_in = 0;
        tick();
        chk("viol ack_b release", ack_b, 0);
        chk("viol idle", busy, 0);

        // randomized phase
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (!sa && !ack_a && $urandom_range(3) == 0) begin
                sa = 1; da = DW'($urandom);
            end else if (sa && ack_a && $urandom_range(2) == 0) begin
                sa = 0;
            end else if (sa && send_out && !gnt && $urandom_range(60) == 0) begin
                sa = 0;
            end
            if (!sb && !ack_b && $urandom_range(3) == 0) begin
                sb = 1; db = DW'($urandom);
            end else if (sb && ack_b && $urandom_range(2) == 0) begin
                sb = 0;
            end
            if (send_out && !ack_in && $urandom_range(2) == 0) ack_in = 1;
            else if (!send_out && ack_in && $urandom_range(2) == 0) ack_in = 0;
            else if (!busy && !ack_in && $urandom_range(80) == 0) ack_in = 1;
            if ($urandom_range(700) == 0) begin
                #1 MR = 1'b1;
                tick();
                #1 MR = 1'b0;
            end
        end

        sa = 0; sb = 0; ack_in = 0;
        tick(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
